// File: rtl/ip_codma_states_pkg.sv
// Shared state encoding, transfer-size codes and size decoding for the
// codma bus responder.
package ip_codma_states_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    GRANT,
    RD_DATA,
    WR_DATA,
    ERR
  } resp_state_t;

  localparam logic [3:0] SIZE_1W   = 4'd0;
  localparam logic [3:0] SIZE_2W   = 4'd1;
  localparam logic [3:0] SIZE_4W   = 4'd2;
  localparam logic [3:0] SIZE_8W   = 4'd3;
  localparam logic [3:0] SIZE_IDLE = 4'd9;

  // Unsupported size codes decode to zero words.
  function automatic logic [3:0] size_to_words(input logic [3:0] size);
    logic [3:0] words;
    words = 4'd0;
    if (size <= SIZE_8W) begin
      words = 4'd1 << size[1:0];
    end
    return words;
  endfunction

endpackage

// File: rtl/ip_codma_bus_responder_if.sv
// codma bus signals between a master and the memory-backed responder.
// Signal suffixes follow the responder's point of view.
interface ip_codma_bus_responder_if;

  logic        bus_read_i;
  logic        bus_write_i;
  logic [3:0]  bus_size_i;
  logic [31:0] bus_addr_i;
  logic        bus_write_valid_i;
  logic [63:0] bus_write_data_i;
  logic        bus_grant_o;
  logic        bus_read_valid_o;
  logic [63:0] bus_read_data_o;
  logic        bus_done_o;
  logic        bus_error_o;

  modport master (
    output bus_read_i, bus_write_i, bus_size_i, bus_addr_i,
           bus_write_valid_i, bus_write_data_i,
    input  bus_grant_o, bus_read_valid_o, bus_read_data_o,
           bus_done_o, bus_error_o
  );

  modport slave (
    input  bus_read_i, bus_write_i, bus_size_i, bus_addr_i,
           bus_write_valid_i, bus_write_data_i,
    output bus_grant_o, bus_read_valid_o, bus_read_data_o,
           bus_done_o, bus_error_o
  );

endinterface

// File: rtl/ip_codma_resp_mem.sv
// Word array for the responder: a word-pair bus port and a single-word
// backdoor port, both with combinational reads. Contents are never reset.
module ip_codma_resp_mem #(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk_i,
  input  logic          bus_we_lo_i,
  input  logic          bus_we_hi_i,
  input  logic [AW-1:0] bus_addr_i,
  input  logic [63:0]   bus_wdata_i,
  output logic [63:0]   bus_rdata_o,
  input  logic          bd_we_i,
  input  logic [AW-1:0] bd_addr_i,
  input  logic [31:0]   bd_wdata_i,
  output logic [31:0]   bd_rdata_o
);

  logic [31:0]   mem_q [DEPTH_WORDS];
  logic [AW:0]   hi_ext;
  logic          hi_ok;
  logic [AW-1:0] hi_addr;

  // The upper word of a pair may fall off the end for single-word transfers.
  assign hi_ext  = {1'b0, bus_addr_i} + {{AW{1'b0}}, 1'b1};
  assign hi_ok   = hi_ext < (AW+1)'(DEPTH_WORDS);
  assign hi_addr = hi_ext[AW-1:0];

  assign bus_rdata_o = {(hi_ok ? mem_q[hi_addr] : 32'h0), mem_q[bus_addr_i]};
  assign bd_rdata_o  = mem_q[bd_addr_i];

  always_ff @(posedge clk_i) begin
    if (bus_we_lo_i) begin
      mem_q[bus_addr_i] <= bus_wdata_i[31:0];
    end
    if (bus_we_hi_i && hi_ok) begin
      mem_q[hi_addr] <= bus_wdata_i[63:32];
    end
    if (bd_we_i) begin
      mem_q[bd_addr_i] <= bd_wdata_i;
    end
  end

endmodule

// File: rtl/ip_codma_bus_responder.sv
// Memory-backed codma bus responder: grants after a programmable latency,
// then streams 64-bit read beats or absorbs 64-bit write beats.
module ip_codma_bus_responder
  import ip_codma_states_pkg::*;
#(
  parameter  int          DEPTH_WORDS   = 256,
  parameter  logic [31:0] ADDR_BASE     = 32'h0000_0000,
  parameter  int          GRANT_LATENCY = 2,
  localparam int          AW            = $clog2(DEPTH_WORDS)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  ip_codma_bus_responder_if.slave bus,
  output logic                   busy_o,
  input  logic                   tb_we_i,
  input  logic [AW-1:0]          tb_addr_i,
  input  logic [31:0]            tb_wdata_i,
  output logic [31:0]            tb_rdata_o
);

  localparam int          LAT_EFF  = (GRANT_LATENCY < 1) ? 1 : GRANT_LATENCY;
  localparam logic [15:0] LAT_INIT = 16'(LAT_EFF - 1);

  resp_state_t   state_q, state_d;
  logic [15:0]   lat_q, lat_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    words_q, words_d;
  logic [2:0]    beats_q, beats_d;
  logic [2:0]    k_q, k_d;
  logic          rd_q, rd_d;

  logic [31:0]   req_off;
  logic [31:0]   req_idx;
  logic [3:0]    req_words;
  logic [2:0]    req_beats;
  logic [32:0]   req_end;
  logic          req_err;

  logic [AW-1:0] beat_addr;
  logic [63:0]   mem_rdata;
  logic          mem_we_lo, mem_we_hi, bd_we;
  logic          last_beat;
  logic          grant, rvalid, done, error;
  logic [63:0]   rdata;

  // Request decode; the end check is one bit wider so it cannot wrap.
  always_comb begin
    req_off   = bus.bus_addr_i - ADDR_BASE;
    req_idx   = req_off >> 2;
    req_words = size_to_words(bus.bus_size_i);
    req_beats = (req_words > 4'd1) ? req_words[3:1] : 3'd1;
    req_end   = {1'b0, req_idx} + {29'd0, req_words};
    req_err   = (bus.bus_addr_i[1:0] != 2'b00) || (bus.bus_size_i > SIZE_8W) ||
                (req_end > 33'(DEPTH_WORDS));
  end

  assign beat_addr = idx_q + AW'({k_q, 1'b0});
  assign last_beat = (k_q == beats_q - 3'd1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      lat_q   <= '0;
      idx_q   <= '0;
      words_q <= '0;
      beats_q <= '0;
      k_q     <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      beats_q <= beats_d;
      k_q     <= k_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    idx_d     = idx_q;
    words_d   = words_q;
    beats_d   = beats_q;
    k_d       = k_q;
    rd_d      = rd_q;
    grant     = 1'b0;
    rvalid    = 1'b0;
    rdata     = 64'h0;
    done      = 1'b0;
    error     = 1'b0;
    mem_we_lo = 1'b0;
    mem_we_hi = 1'b0;
    bd_we     = 1'b0;
    unique case (state_q)
      IDLE: begin
        bd_we = tb_we_i;
        if (bus.bus_read_i || bus.bus_write_i) begin
          idx_d   = req_idx[AW-1:0];
          words_d = req_words;
          beats_d = req_beats;
          rd_d    = bus.bus_read_i;
          if (req_err) begin
            state_d = ERR;
          end else if (LAT_INIT == 16'd0) begin
            state_d = GRANT;
          end else begin
            state_d = WAIT;
            lat_d   = LAT_INIT;
          end
        end
      end
      WAIT: begin
        lat_d = lat_q - 16'd1;
        if (lat_q == 16'd1) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        grant   = 1'b1;
        k_d     = 3'd0;
        state_d = rd_q ? RD_DATA : WR_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        rdata  = {((words_q > 4'd1) ? mem_rdata[63:32] : 32'h0), mem_rdata[31:0]};
        k_d    = k_q + 3'd1;
        if (last_beat) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      WR_DATA: begin
        // A low write_valid is a stall: nothing written, nothing counted.
        if (bus.bus_write_valid_i) begin
          mem_we_lo = 1'b1;
          mem_we_hi = (words_q > 4'd1);
          k_d       = k_q + 3'd1;
          if (last_beat) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ERR: begin
        error   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bus_grant_o      = grant;
  assign bus.bus_read_valid_o = rvalid;
  assign bus.bus_read_data_o  = rdata;
  assign bus.bus_done_o       = done;
  assign bus.bus_error_o      = error;
  assign busy_o               = (state_q != IDLE);

  ip_codma_resp_mem #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem (
    .clk_i      (clk_i),
    .bus_we_lo_i(mem_we_lo),
    .bus_we_hi_i(mem_we_hi),
    .bus_addr_i (beat_addr),
    .bus_wdata_i(bus.bus_write_data_i),
    .bus_rdata_o(mem_rdata),
    .bd_we_i    (bd_we),
    .bd_addr_i  (tb_addr_i),
    .bd_wdata_i (tb_wdata_i),
    .bd_rdata_o (tb_rdata_o)
  );

endmodule

// File: tb/tb_ip_codma_bus_responder.sv
// Self-checking bench for ip_codma_bus_responder: a transaction-level model
// predicts every output cycle by cycle; a few literal checks pin the model.
module tb_ip_codma_bus_responder;

  localparam int          DEPTH = 256;
  localparam int          LAT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        busy_o;
  logic        tb_we_i;
  logic [7:0]  tb_addr_i;
  logic [31:0] tb_wdata_i;
  logic [31:0] tb_rdata_o;

  ip_codma_bus_responder_if busIf ();

  ip_codma_bus_responder #(
    .DEPTH_WORDS  (DEPTH),
    .ADDR_BASE    (BASE),
    .GRANT_LATENCY(LAT)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .bus       (busIf),
    .busy_o    (busy_o),
    .tb_we_i   (tb_we_i),
    .tb_addr_i (tb_addr_i),
    .tb_wdata_i(tb_wdata_i),
    .tb_rdata_o(tb_rdata_o)
  );

  always #5 clk_i = ~clk_i;

  logic [31:0] memModel [DEPTH];
  logic [63:0] wBeats [4];
  logic        expGrant, expRvalid, expDone, expError, expBusy;
  logic [63:0] expRdata;
  bit          checkEn = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          cycleCnt = 0;
  int          grantCnt = 0, doneCnt = 0, errCnt = 0;
  int          lastGrantCyc = 0, lastDoneCyc = 0;
  bit          firstSeen = 1'b0;
  logic [63:0] firstBeat = 64'h0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Cycle numbering: a slot starts just after a rising edge and owns that count.
  always @(posedge clk_i) cycleCnt <= cycleCnt + 1;

  // Every cycle, compare all outputs against what the model predicted for it.
  always @(negedge clk_i) begin
    if (checkEn && !reset_i) begin
      checkOutput("grant",  64'(busIf.bus_grant_o),      64'(expGrant));
      checkOutput("rvalid", 64'(busIf.bus_read_valid_o), 64'(expRvalid));
      checkOutput("rdata",  busIf.bus_read_data_o,       expRdata);
      checkOutput("done",   64'(busIf.bus_done_o),       64'(expDone));
      checkOutput("error",  64'(busIf.bus_error_o),      64'(expError));
      checkOutput("busy",   64'(busy_o),                 64'(expBusy));
      checkOutput("tbRdata", 64'(tb_rdata_o),            64'(memModel[tb_addr_i]));
    end
  end

  // Event log used by the literal timing and count checks.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (busIf.bus_grant_o) begin
        grantCnt++;
        lastGrantCyc = cycleCnt;
      end
      if (busIf.bus_done_o) begin
        doneCnt++;
        lastDoneCyc = cycleCnt;
      end
      if (busIf.bus_error_o) errCnt++;
      if (busIf.bus_read_valid_o && !firstSeen) begin
        firstSeen = 1'b1;
        firstBeat = busIf.bus_read_data_o;
      end
    end
  end

  task automatic driveSlot(input logic rd, input logic wr, input logic [3:0] size,
                           input logic [31:0] addr, input logic wv, input logic [63:0] wd,
                           input logic eG, input logic eRv, input logic [63:0] eRd,
                           input logic eD, input logic eE, input logic eB);
    busIf.bus_read_i        = rd;
    busIf.bus_write_i       = wr;
    busIf.bus_size_i        = size;
    busIf.bus_addr_i        = addr;
    busIf.bus_write_valid_i = wv;
    busIf.bus_write_data_i  = wd;
    expGrant  = eG;
    expRvalid = eRv;
    expRdata  = eRd;
    expDone   = eD;
    expError  = eE;
    expBusy   = eB;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [3:0] size,
                               input logic [31:0] addr, input logic wv, input logic [63:0] wd,
                               input logic eG, input logic eRv, input logic [63:0] eRd,
                               input logic eD, input logic eE, input logic eB);
    driveSlot(rd, wr, size, addr, wv, wd, eG, eRv, eRd, eD, eE, eB);
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleCycle();
    tb_addr_i = 8'($urandom);
    applyStimulus(1'b0, 1'b0, 4'd9, 32'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic bdWrite(input int idx, input logic [31:0] data);
    tb_we_i    = 1'b1;
    tb_addr_i  = 8'(idx);
    tb_wdata_i = data;
    applyStimulus(1'b0, 1'b0, 4'd9, 32'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    memModel[idx] = data;
    tb_we_i = 1'b0;
  endtask

  task automatic peekCheck(input string name, input int idx, input logic [31:0] required);
    tb_addr_i = 8'(idx);
    #1;
    checkOutput(name, 64'(tb_rdata_o), 64'(required));
    idleCycle();
  endtask

  // One whole transfer starting at its sample cycle; the responder is assumed idle.
  task automatic doTransfer(input bit isRead, input bit alsoWrite, input logic [31:0] addr,
                            input logic [3:0] size, input int maxStall, input bit fixedStall);
    int words, beats, idx, stalls;
    bit err;
    logic [63:0] rd;
    words = (size <= 4'd3) ? (1 << size) : 0;
    idx   = int'((addr - BASE) >> 2);
    err   = (addr[1:0] != 2'b00) || (size > 4'd3) || (idx + words > DEPTH);
    beats = (words > 1) ? words / 2 : 1;
    tb_addr_i = 8'($urandom);
    applyStimulus(isRead, !isRead || alsoWrite, size, addr, 1'b0, {$urandom, $urandom},
                  1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    if (err) begin
      applyStimulus(1'b0, alsoWrite, 4'($urandom), $urandom, 1'b0, 64'h0,
                    1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
      return;
    end
    // Backdoor writes while waiting must be dropped, so the model ignores them.
    for (int c = 1; c < LAT; c++) begin
      tb_we_i    = 1'($urandom_range(0, 1));
      tb_addr_i  = 8'($urandom);
      tb_wdata_i = $urandom;
      applyStimulus(1'b0, alsoWrite, 4'($urandom), $urandom, 1'b0, 64'h0,
                    1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
      tb_we_i = 1'b0;
    end
    applyStimulus(1'b0, alsoWrite, 4'($urandom), $urandom, 1'b0, 64'h0,
                  1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    if (isRead) begin
      for (int k = 0; k < beats; k++) begin
        rd = {((words > 1) ? memModel[idx + 2*k + 1] : 32'h0), memModel[idx + 2*k]};
        tb_addr_i = 8'($urandom);
        applyStimulus(1'b0, alsoWrite, 4'($urandom), $urandom, 1'b0, 64'h0,
                      1'b0, 1'b1, rd, (k == beats - 1), 1'b0, 1'b1);
      end
    end else begin
      for (int k = 0; k < beats; k++) begin
        stalls = fixedStall ? ((k > 0) ? 1 : 0) : int'($urandom_range(0, maxStall));
        repeat (stalls) begin
          applyStimulus(1'b0, alsoWrite, 4'($urandom), $urandom, 1'b0, {$urandom, $urandom},
                        1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, alsoWrite, 4'($urandom), $urandom, 1'b1, wBeats[k],
                      1'b0, 1'b0, 64'h0, (k == beats - 1), 1'b0, 1'b1);
        memModel[idx + 2*k] = wBeats[k][31:0];
        if (words > 1) memModel[idx + 2*k + 1] = wBeats[k][63:32];
      end
    end
  endtask

  initial begin
    int mark, g0, e0, d0, sizeSel;
    bit isRead;
    logic [3:0] size;
    logic [31:0] addr;

    reset_i    = 1'b1;
    tb_we_i    = 1'b0;
    tb_addr_i  = 8'h0;
    tb_wdata_i = 32'h0;
    driveSlot(1'b0, 1'b0, 4'd9, 32'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #2;
    checkOutput("rstGrant",  64'(busIf.bus_grant_o),      64'h0);
    checkOutput("rstRvalid", 64'(busIf.bus_read_valid_o), 64'h0);
    checkOutput("rstRdata",  busIf.bus_read_data_o,       64'h0);
    checkOutput("rstDone",   64'(busIf.bus_done_o),       64'h0);
    checkOutput("rstError",  64'(busIf.bus_error_o),      64'h0);
    checkOutput("rstBusy",   64'(busy_o),                 64'h0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    for (int i = 0; i < DEPTH; i++) bdWrite(i, $urandom);
    for (int i = 0; i < 8; i++) bdWrite(i, 32'h1000_0000 + 32'(i));
    bdWrite(9, 32'h5555_9999);
    checkEn = 1'b1;

    $display("[TB] burst read");
    mark = cycleCnt;
    firstSeen = 1'b0;
    doTransfer(1'b1, 1'b0, 32'h0, 4'd3, 0, 1'b0);
    checkOutput("burstGrantCyc", 64'(lastGrantCyc - mark), 64'd2);
    checkOutput("burstDoneCyc",  64'(lastDoneCyc - mark),  64'd6);
    checkOutput("burstFirstBeat", firstBeat, 64'h1000_0001_1000_0000);

    $display("[TB] reset during read");
    d0 = doneCnt;
    applyStimulus(1'b1, 1'b0, 4'd3, 32'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd9, 32'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 4'd9, 32'h0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 4'd9, 32'h0, 1'b0, 64'h0, 1'b0, 1'b1,
                    {memModel[2*k + 1], memModel[2*k]}, 1'b0, 1'b0, 1'b1);
    end
    driveSlot(1'b0, 1'b0, 4'd9, 32'h0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    #1;
    reset_i = 1'b1;
    #1;
    checkOutput("midRstRvalid", 64'(busIf.bus_read_valid_o), 64'h0);
    checkOutput("midRstRdata",  busIf.bus_read_data_o,       64'h0);
    checkOutput("midRstDone",   64'(busIf.bus_done_o),       64'h0);
    checkOutput("midRstBusy",   64'(busy_o),                 64'h0);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    repeat (2) idleCycle();
    checkOutput("midRstNoDone", 64'(doneCnt - d0), 64'h0);
    peekCheck("retainMem2", 2, 32'h1000_0002);
    peekCheck("retainMem7", 7, 32'h1000_0007);

    $display("[TB] write with stall");
    wBeats[0] = 64'hBBBB_0001_AAAA_0000;
    wBeats[1] = 64'hBBBB_0003_AAAA_0002;
    mark = cycleCnt;
    doTransfer(1'b0, 1'b0, 32'h10, 4'd2, 0, 1'b1);
    checkOutput("stallDoneCyc", 64'(lastDoneCyc - mark), 64'd5);
    peekCheck("wrMem4", 4, 32'hAAAA_0000);
    peekCheck("wrMem5", 5, 32'hBBBB_0001);
    peekCheck("wrMem6", 6, 32'hAAAA_0002);
    peekCheck("wrMem7", 7, 32'hBBBB_0003);

    $display("[TB] single-word write");
    wBeats[0] = 64'hFFFF_FFFF_DEAD_BEEF;
    doTransfer(1'b0, 1'b0, 32'h20, 4'd0, 0, 1'b0);
    peekCheck("singleMem8", 8, 32'hDEAD_BEEF);
    peekCheck("singleMem9", 9, 32'h5555_9999);
    firstSeen = 1'b0;
    doTransfer(1'b1, 1'b0, 32'h20, 4'd0, 0, 1'b0);
    checkOutput("singleReadback", firstBeat, 64'h0000_0000_DEAD_BEEF);

    $display("[TB] error cases");
    wBeats[0] = 64'h0123_4567_89AB_CDEF;
    wBeats[1] = 64'h0123_4567_89AB_CDEF;
    e0 = errCnt;
    g0 = grantCnt;
    doTransfer(1'b0, 1'b0, 32'h3FC, 4'd1, 0, 1'b0);
    doTransfer(1'b0, 1'b0, 32'h2, 4'd0, 0, 1'b0);
    doTransfer(1'b1, 1'b0, 32'h0, 4'd5, 0, 1'b0);
    idleCycle();
    checkOutput("errPulses", 64'(errCnt - e0), 64'd3);
    checkOutput("errNoGrant", 64'(grantCnt - g0), 64'd0);
    peekCheck("errMem0", 0, 32'h1000_0000);
    peekCheck("errMem255", 255, memModel[255]);

    $display("[TB] read and write together");
    wBeats[0] = 64'hCAFE_0001_CAFE_0000;
    firstSeen = 1'b0;
    g0 = grantCnt;
    mark = cycleCnt;
    doTransfer(1'b1, 1'b1, 32'h0, 4'd1, 0, 1'b0);
    doTransfer(1'b0, 1'b0, 32'h0, 4'd1, 0, 1'b0);
    checkOutput("bothReadFirst", firstBeat, 64'h1000_0001_1000_0000);
    checkOutput("bothWriteGrantCyc", 64'(lastGrantCyc - mark), 64'd6);
    checkOutput("bothGrants", 64'(grantCnt - g0), 64'd2);
    peekCheck("bothMem0", 0, 32'hCAFE_0000);
    peekCheck("bothMem1", 1, 32'hCAFE_0001);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 60; t++) begin
      isRead  = 1'($urandom_range(0, 1));
      sizeSel = int'($urandom_range(0, 9));
      size    = (sizeSel < 8) ? 4'(sizeSel % 4) : ((sizeSel == 8) ? 4'd9 : 4'd5);
      addr    = 32'($urandom_range(0, DEPTH - 1)) << 2;
      if ($urandom_range(0, 9) == 0) addr = addr | 32'($urandom_range(1, 3));
      for (int k = 0; k < 4; k++) wBeats[k] = {$urandom, $urandom};
      doTransfer(isRead, 1'b0, addr, size, 2, 1'b0);
      if ($urandom_range(0, 2) == 0) bdWrite(int'($urandom_range(0, DEPTH - 1)), $urandom);
      repeat ($urandom_range(0, 1)) idleCycle();
    end

    idleCycle();
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ip_codma_bus_responder.md
Name: ip_codma_bus_responder

Overview:
- Memory-backed bus responder (slave) for the codma bus protocol; it answers the read/write requests the codma master issues.
- Holds a word-addressed memory and returns a grant after a programmable latency.
- Streams 64-bit read beats, or absorbs 64-bit write beats, then pulses done.
- Used as the system-memory model for codma bring-up, and as a simple on-chip scratch RAM.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit memory words.
- ADDR_BASE, 32'h0000_0000: byte address of word 0.
- GRANT_LATENCY, 2: cycles from request sample to grant; values below 1 are treated as 1.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- bus_read_i  in  1  master read request, level.
- bus_write_i  in  1  master write request, level.
- bus_size_i  in  4  transfer size code: 0=1 word, 1=2, 2=4, 3=8; 9 = idle; any other value is an error.
- bus_addr_i  in  32  byte address, word aligned.
- bus_write_valid_i  in  1  write beat present.
- bus_write_data_i  in  64  write beat: [31:0] lower word, [63:32] upper word.
- bus_grant_o  out  1  one-cycle grant pulse.
- bus_read_valid_o  out  1  read beat valid.
- bus_read_data_o  out  64  read beat, same word packing as write.
- bus_done_o  out  1  pulse on the last beat.
- bus_error_o  out  1  pulse on a rejected request.
- busy_o  out  1  high when not IDLE.
- tb_we_i  in  1  backdoor write strobe.
- tb_addr_i  in  $clog2(DEPTH_WORDS)  backdoor word index.
- tb_wdata_i  in  32  backdoor write data.
- tb_rdata_o  out  32  combinational backdoor read of mem[tb_addr_i].

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Memory array is not reset and keeps its contents through reset. Reset asserted mid-transfer aborts immediately; no done pulse.
- States: IDLE, WAIT, GRANT, RD_DATA, WR_DATA, ERR.
- IDLE:
  - Samples requests every cycle; read has priority when read and write are both high.
  - Latches addr and size, and computes word index = (addr - ADDR_BASE) >> 2, words = 1 << size, beats = max(1, words/2).
  - Error condition: addr[1:0] != 0, size code > 3, or index + words > DEPTH_WORDS. On error go to ERR.
  - Otherwise go to WAIT with the latency counter set to GRANT_LATENCY - 1; if that value is 0, go directly to GRANT.
- ERR: bus_error_o = 1 for one cycle, then IDLE. No grant is issued and memory is untouched.
- WAIT: decrement the counter; go to GRANT when it reaches 0. Grant is therefore high exactly GRANT_LATENCY cycles after the sample cycle. Request deassertion during WAIT is ignored; the transfer completes anyway.
- GRANT: bus_grant_o = 1 for one cycle, then RD_DATA or WR_DATA with beat counter k = 0.
- RD_DATA:
  - bus_read_valid_o = 1 on consecutive cycles, with no stalls.
  - Beat k drives {mem[idx+2k+1], mem[idx+2k]}.
  - For size 0 the upper half is 32'h0.
  - bus_done_o is asserted with the last beat; next state IDLE.
  - bus_read_data_o is 0 whenever read_valid is low.
- WR_DATA:
  - Beats are accepted only when bus_write_valid_i = 1; a low cycle stalls with no write and no count.
  - Each accepted beat k writes mem[idx+2k] = data[31:0] and, if words > 1, mem[idx+2k+1] = data[63:32].
  - The memory write takes effect at the clock edge.
  - bus_done_o is asserted in the cycle the last beat is accepted; next state IDLE.
- Backdoor: tb_we_i is honoured only in IDLE and is silently dropped otherwise. tb_rdata_o is always live.
- Requests are ignored in every state except IDLE. A level request still high in the cycle after done is sampled as a new transfer.

Decomposition:
- Add to ip_codma_states_pkg:
  - resp_state_t enum (IDLE, WAIT, GRANT, RD_DATA, WR_DATA, ERR);
  - size-code constants SIZE_1W=0, SIZE_2W=1, SIZE_4W=2, SIZE_8W=3, SIZE_IDLE=9;
  - function size_to_words().
- One sub-module: ip_codma_resp_mem, a 1-write/2-read word array with a bus port and a backdoor port. The FSM and counters stay in the top.

Test Plan:
- Burst read: backdoor mem[i] = 32'h1000_0000+i for i = 0..7; read addr 0x0, size 3, GRANT_LATENCY 2.
  - Grant in cycle 2; read_valid in cycles 3-6.
  - First beat 64'h1000_0001_1000_0000; done in cycle 6.
- Write with stall: write addr 0x10, size 2; beats 64'hBBBB_0001_AAAA_0000 and 64'hBBBB_0003_AAAA_0002, with write_valid low for one cycle between them.
  - mem[4..7] = AAAA_0000, BBBB_0001, AAAA_0002, BBBB_0003.
  - Done coincides with the second accepted beat.
- Single-word write: size 0, addr 0x20, data 64'hFFFF_FFFF_DEAD_BEEF.
  - mem[8] = DEAD_BEEF; mem[9] unchanged. Readback beat = 64'h0000_0000_DEAD_BEEF.
- Error cases, each giving a single error pulse, no grant, and memory unchanged:
  - addr 0x3FC, size 1, DEPTH 256;
  - addr 0x2 (misaligned);
  - size 5.
- Read and write raised together on addr 0x0, size 1: read served first, and write granted after the read's done. The write-request-held case is covered by re-sampling.
- Reset asserted mid-read at beat 2: all outputs go to 0 without waiting for a clock, state IDLE, no done pulse; tb_rdata_o shows memory retained.
